// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling 8N1 UART receiver on the system clock.
// The line is synchronised, oversampled at OS ticks per bit and sampled mid-bit.
// False starts are rejected and bad stop bits are flagged. A one-byte holding
// register with a valid/ready handshake faces the consumer.
module uart_rx_os #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int OS     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = CLK_HZ / (BAUD * OS);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_MID   = OW'(OS / 2 - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // synchroniser, tick divider and previous-tick line sample
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic          rx_d_q, rx_d_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick;

    // receive FSM and datapath
    state_t        state_q, state_d;
    logic [OW-1:0] os_cnt_q, os_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          complete;
    logic          ferr_set;

    // holding register and status
    logic [7:0]    rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    // Free-running tick divider, line synchroniser and once-per-tick line history
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        rx_d_d    = tick ? rx_s_q : rx_d_q;
    end

    // Sync flops and the previous sample come out of reset high, so an idle line is not seen as an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
            div_cnt_q <= '0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_d_q    <= rx_d_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // Receive FSM: it advances only on tick cycles and samples each bit at its centre
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        complete  = 1'b0;
        ferr_set  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    // A start needs a high-to-low edge, so a held-low line (break) cannot retrigger.
                    if (rx_d_q && !rx_s_q) begin
                        state_d  = START;
                        os_cnt_d = '0;
                    end
                end
                START: begin
                    if (os_cnt_q == OS_MID) begin
                        if (!rx_s_q) begin
                            state_d   = DATA;
                            os_cnt_d  = '0;
                            bit_cnt_d = '0;
                        end else begin
                            // The line went high again by mid-bit, so the edge was a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (os_cnt_q == OS_LAST) begin
                        shift_d  = {rx_s_q, shift_q[7:1]};
                        os_cnt_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (os_cnt_q == OS_LAST) begin
                        state_d  = IDLE;
                        os_cnt_d = '0;
                        if (rx_s_q) begin
                            complete = 1'b1;
                        end else begin
                            ferr_set = 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and datapath registers; reset drops any partially received byte
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Holding register handshake: a byte that completes while the register is full and not being read is dropped and flagged
    always_comb begin
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        overrun_d   = overrun_q;
        frame_err_d = ferr_set;
        if (rvalid_q && rready) begin
            rvalid_d  = 1'b0;
            overrun_d = 1'b0;
        end
        if (complete) begin
            if (!rvalid_q || rready) begin
                rdata_d  = shift_q;
                rvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed vectors and hand-written sequences for uart_rx_os.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int BIT   = 434;          // clk per bit at 115200 baud
    localparam int TPER  = 27;           // clk per oversampling tick
    localparam int LAT0  = 3 + 152*TPER; // start edge to rvalid when the tick lands immediately

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rready = 1'b0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // event monitor (only this process writes these)
    int         n_vrise = 0;
    int         n_vhi = 0;
    int         n_ferr = 0;
    int         rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    logic       rv_prev = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_rise;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    uart_rx_os dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rdata(rdata),
        .rvalid(rvalid),
        .rready(rready),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rvalid && !rv_prev) begin
            n_vrise   = n_vrise + 1;
            rise_cyc  = cyc;
            rise_data = rdata;
        end
        rv_prev = rvalid;
        if (rvalid) n_vhi = n_vhi + 1;
        if (frame_err) n_ferr = n_ferr + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
        total = total + 1;
        if (v < lo || v > hi) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d..%0d", nm, v, lo, hi);
        end
    endtask

    // caller is at a negedge; returns at a negedge with rx still at the stop value
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * BIT) @(negedge clk);
    endtask

    initial begin
        int b_r, b_h, b_f, c0, c0_2, w2, rise2, lat;
        logic [7:0] d96;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h5A, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'h01, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'h80, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'hC3, stop: 1'b0, exp_rise: 0, exp_ferr: 1};

        // reset state
        repeat (5) @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        rready = 1'b1;
        idle(2);

        // table-driven frames, consumer always ready
        for (int i = 0; i < 5; i++) begin
            b_r = n_vrise; b_h = n_vhi; b_f = n_ferr;
            c0 = cyc;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(1);
            chk($sformatf("tbl%0d_rise", i), n_vrise - b_r, vecs[i].exp_rise);
            chk($sformatf("tbl%0d_vhi", i), n_vhi - b_h, vecs[i].exp_rise);
            chk($sformatf("tbl%0d_ferr", i), n_ferr - b_f, vecs[i].exp_ferr);
            chk($sformatf("tbl%0d_ovr", i), overrun, 0);
            if (vecs[i].exp_rise == 1 && n_vrise - b_r == 1) begin
                chk($sformatf("tbl%0d_data", i), rise_data, vecs[i].data);
                lat = rise_cyc - c0;
                chk_rng($sformatf("tbl%0d_lat", i), lat, 4104, 4135);
            end
        end

        // overrun: two frames back to back with consumer stalled
        rready = 1'b0;
        send_frame(8'h00, 1'b1);
        chk("ovr_v1", rvalid, 1);
        chk("ovr_d1", rdata, 8'h00);
        chk("ovr_o1", overrun, 0);
        send_frame(8'hFF, 1'b1);
        idle(1);
        chk("ovr_v2", rvalid, 1);
        chk("ovr_d2", rdata, 8'h00);
        chk("ovr_o2", overrun, 1);
        rready = 1'b1;
        @(negedge clk);
        chk("ovr_acc_v", rvalid, 0);
        chk("ovr_acc_o", overrun, 0);

        // 100 clk low glitch on an idle line
        b_r = n_vrise; b_f = n_ferr;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        idle(11);
        chk("glitch_rise", n_vrise - b_r, 0);
        chk("glitch_ferr", n_ferr - b_f, 0);

        // bad stop bit followed by a long break, then a good frame
        b_r = n_vrise; b_f = n_ferr;
        send_frame(8'h3C, 1'b0);
        repeat (20 * BIT) @(negedge clk);
        idle(1);
        send_frame(8'h5A, 1'b1);
        idle(1);
        chk("brk_ferr", n_ferr - b_f, 1);
        chk("brk_rise", n_vrise - b_r, 1);
        chk("brk_data", rise_data, 8'h5A);

        // accept of 0x11 lands in the same clk that 0x22 completes
        rready = 1'b0;
        b_r = n_vrise;
        send_frame(8'h11, 1'b1);
        chk("same_r1", n_vrise - b_r, 1);
        c0_2 = cyc;
        w2 = (((rise_cyc - LAT0 - 1 - c0_2) % TPER) + TPER) % TPER;
        rise2 = c0_2 + LAT0 + 1 + w2;
        fork
            send_frame(8'h22, 1'b1);
            begin
                while (cyc < rise2 - 1) @(negedge clk);
                rready = 1'b1;
                @(negedge clk);
                chk("same_rvalid", rvalid, 1);
                chk("same_rdata", rdata, 8'h22);
                chk("same_ovr", overrun, 0);
                @(negedge clk);
                chk("same_drain", rvalid, 0);
            end
        join
        idle(1);

        // reset in the middle of bit 4 of 0x96
        rready = 1'b0;
        send_frame(8'h7E, 1'b1);
        idle(1);
        chk("mid_pre_v", rvalid, 1);
        d96 = 8'h96;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d96[i];
            repeat (BIT) @(negedge clk);
        end
        rx = d96[4];
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_ovr", overrun, 0);
        reset = 1'b0;
        rready = 1'b1;
        idle(2);
        b_r = n_vrise; b_f = n_ferr;
        send_frame(8'h69, 1'b1);
        idle(1);
        chk("mid_rise", n_vrise - b_r, 1);
        chk("mid_data", rise_data, 8'h69);
        chk("mid_ferr", n_ferr - b_f, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
